// File: rtl/rat_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rat_table_pkg
// Description : Shared widths, id typedefs and constants for the register
//               alias table and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package rat_table_pkg;

    localparam int PHY_REG_NUM       = 64;
    localparam int ARCH_REG_NUM      = 32;
    localparam int RENAME_WIDTH      = 2;
    localparam int COMMIT_WIDTH      = 2;
    localparam int READ_PORTS        = 3;

    localparam int PHY_REG_ID_WIDTH  = $clog2(PHY_REG_NUM);
    localparam int ARCH_REG_ID_WIDTH = $clog2(ARCH_REG_NUM);
    // Arch ids are carried wide enough to hold the 255 "unused" sentinel.
    localparam int ARCH_ID_WIDTH     = (ARCH_REG_ID_WIDTH > 8) ? ARCH_REG_ID_WIDTH : 8;

    typedef logic [PHY_REG_ID_WIDTH-1:0] phy_id_t;
    typedef logic [ARCH_ID_WIDTH-1:0]    arch_id_t;

    localparam arch_id_t ARCH_ID_NONE = arch_id_t'(255);

    // Valid/visible image after reset: the first ARCH_REG_NUM entries hold
    // the identity mapping, the rest are free.
    localparam logic [PHY_REG_NUM-1:0] RESET_VEC =
        {{(PHY_REG_NUM-ARCH_REG_NUM){1'b0}}, {ARCH_REG_NUM{1'b1}}};

endpackage : rat_table_pkg
`default_nettype wire

// File: rtl/rat_table_if.sv
`default_nettype none
// ============================================================================
// Module      : rat_table_if
// Description : Rename/commit side bus of the register alias table.
//               master = rename + commit stages, slave = alias table.
// Revision    : 1.0 - initial release
// ============================================================================
interface rat_table_if;
    import rat_table_pkg::*;

    // rename side
    phy_id_t                    rat_rename_new_phy_id        [RENAME_WIDTH];
    logic [RENAME_WIDTH-1:0]    rat_rename_new_phy_id_valid;
    phy_id_t                    rename_rat_phy_id            [RENAME_WIDTH];
    logic [RENAME_WIDTH-1:0]    rename_rat_phy_id_valid;
    arch_id_t                   rename_rat_arch_id           [RENAME_WIDTH];
    logic                       rename_rat_map;
    arch_id_t                   rename_rat_read_arch_id      [RENAME_WIDTH][READ_PORTS];
    phy_id_t                    rat_rename_read_phy_id       [RENAME_WIDTH][READ_PORTS];
    logic [PHY_REG_NUM-1:0]     rat_rename_map_table_valid;
    logic [PHY_REG_NUM-1:0]     rat_rename_map_table_visible;

    // commit side
    logic [PHY_REG_NUM-1:0]     commit_rat_map_table_valid;
    logic [PHY_REG_NUM-1:0]     commit_rat_map_table_visible;
    logic                       commit_rat_map_table_restore;
    phy_id_t                    commit_rat_release_phy_id    [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]    commit_rat_release_phy_id_valid;
    logic                       commit_rat_release_map;
    phy_id_t                    commit_rat_commit_phy_id     [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]    commit_rat_commit_phy_id_valid;
    logic                       commit_rat_commit_map;
    phy_id_t                    commit_rat_restore_new_phy_id;
    phy_id_t                    commit_rat_restore_old_phy_id;
    logic                       commit_rat_restore_map;

    modport master (
        input  rat_rename_new_phy_id, rat_rename_new_phy_id_valid,
               rat_rename_read_phy_id, rat_rename_map_table_valid,
               rat_rename_map_table_visible,
        output rename_rat_phy_id, rename_rat_phy_id_valid, rename_rat_arch_id,
               rename_rat_map, rename_rat_read_arch_id,
               commit_rat_map_table_valid, commit_rat_map_table_visible,
               commit_rat_map_table_restore,
               commit_rat_release_phy_id, commit_rat_release_phy_id_valid,
               commit_rat_release_map,
               commit_rat_commit_phy_id, commit_rat_commit_phy_id_valid,
               commit_rat_commit_map,
               commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id,
               commit_rat_restore_map
    );

    modport slave (
        output rat_rename_new_phy_id, rat_rename_new_phy_id_valid,
               rat_rename_read_phy_id, rat_rename_map_table_valid,
               rat_rename_map_table_visible,
        input  rename_rat_phy_id, rename_rat_phy_id_valid, rename_rat_arch_id,
               rename_rat_map, rename_rat_read_arch_id,
               commit_rat_map_table_valid, commit_rat_map_table_visible,
               commit_rat_map_table_restore,
               commit_rat_release_phy_id, commit_rat_release_phy_id_valid,
               commit_rat_release_map,
               commit_rat_commit_phy_id, commit_rat_commit_phy_id_valid,
               commit_rat_commit_map,
               commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id,
               commit_rat_restore_map
    );

endinterface : rat_table_if
`default_nettype wire

// File: rtl/rat_table_free_finder.sv
`default_nettype none
// ============================================================================
// Module      : rat_free_finder
// Description : Finds the RENAME_WIDTH lowest-index free (valid=0) entries.
//               Slot r receives the (r+1)-th free entry.
// Revision    : 1.0 - initial release
// ============================================================================
module rat_free_finder
    import rat_table_pkg::*;
(
    input  wire logic [PHY_REG_NUM-1:0]  i_valid,
    output phy_id_t                      o_phy_id       [RENAME_WIDTH],
    output logic [RENAME_WIDTH-1:0]      o_phy_id_valid
);

    logic [PHY_REG_NUM-1:0] w_taken;
    phy_id_t                w_pick;
    logic                   w_hit;

    // Successive lowest-zero searches; each pick is masked before the next slot searches.
    always_comb begin
        w_taken        = i_valid;
        w_pick         = '0;
        w_hit          = 1'b0;
        o_phy_id_valid = '0;
        for (int r = 0; r < RENAME_WIDTH; r++) begin
            o_phy_id[r] = '0;
        end
        for (int r = 0; r < RENAME_WIDTH; r++) begin
            w_hit  = 1'b0;
            w_pick = '0;
            // Descending scan: the last hit written is the lowest index.
            for (int i = PHY_REG_NUM - 1; i >= 0; i--) begin
                if (!w_taken[i]) begin
                    w_hit  = 1'b1;
                    w_pick = phy_id_t'(i);
                end
            end
            o_phy_id[r]       = w_pick;
            o_phy_id_valid[r] = w_hit;
            if (w_hit) begin
                w_taken[w_pick] = 1'b1;
            end
        end
    end

endmodule : rat_free_finder
`default_nettype wire

// File: rtl/rat_table.sv
`default_nettype none
// ============================================================================
// Module      : rat_table
// Description : Register alias table of the rename stage. One entry per
//               physical register holding (arch id, valid, visible). Offers
//               free registers, resolves source lookups, and applies rename,
//               release, rollback, commit and full-restore updates.
//               Optional macro RAT_ASSERT_EN enables simulation checks.
// Revision    : 1.0 - initial release
// ============================================================================
module rat_table
    import rat_table_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    rat_table_if.slave  bus
);

    arch_id_t               r_arch [PHY_REG_NUM];
    logic [PHY_REG_NUM-1:0] r_valid;
    logic [PHY_REG_NUM-1:0] r_visible;

    arch_id_t               w_arch_nxt [PHY_REG_NUM];
    logic [PHY_REG_NUM-1:0] w_valid_nxt;
    logic [PHY_REG_NUM-1:0] w_visible_nxt;

    phy_id_t                w_read_phy  [RENAME_WIDTH][READ_PORTS];
    phy_id_t                w_new_phy   [RENAME_WIDTH];
    logic [RENAME_WIDTH-1:0] w_new_valid;

    // Free-register offers derived from the registered valid vector only.
    rat_free_finder u_free_finder (
        .i_valid        (r_valid),
        .o_phy_id       (w_new_phy),
        .o_phy_id_valid (w_new_valid)
    );

    // CAM lookup: OR of the ids of matching live entries (at most one when the table is consistent).
    always_comb begin
        for (int r = 0; r < RENAME_WIDTH; r++) begin
            for (int k = 0; k < READ_PORTS; k++) begin
                w_read_phy[r][k] = '0;
                if (bus.rename_rat_read_arch_id[r][k] != ARCH_ID_NONE) begin
                    for (int i = 0; i < PHY_REG_NUM; i++) begin
                        if (r_valid[i] && r_visible[i] &&
                            (r_arch[i] == bus.rename_rat_read_arch_id[r][k])) begin
                            w_read_phy[r][k] = w_read_phy[r][k] | phy_id_t'(i);
                        end
                    end
                end
            end
        end
    end

    // Next-state: full restore overrides everything; otherwise release, rollback, commit, rename in order.
    always_comb begin
        w_arch_nxt    = r_arch;
        w_valid_nxt   = r_valid;
        w_visible_nxt = r_visible;
        if (bus.commit_rat_map_table_restore) begin
            w_valid_nxt   = bus.commit_rat_map_table_valid;
            w_visible_nxt = bus.commit_rat_map_table_visible;
        end else begin
            if (bus.commit_rat_release_map) begin
                for (int c = 0; c < COMMIT_WIDTH; c++) begin
                    if (bus.commit_rat_release_phy_id_valid[c]) begin
                        w_valid_nxt[bus.commit_rat_release_phy_id[c]]   = 1'b0;
                        w_visible_nxt[bus.commit_rat_release_phy_id[c]] = 1'b0;
                    end
                end
            end
            if (bus.commit_rat_restore_map) begin
                w_valid_nxt[bus.commit_rat_restore_new_phy_id]   = 1'b0;
                w_visible_nxt[bus.commit_rat_restore_new_phy_id] = 1'b0;
                w_visible_nxt[bus.commit_rat_restore_old_phy_id] = 1'b1;
            end
            if (bus.commit_rat_commit_map) begin
                for (int c = 0; c < COMMIT_WIDTH; c++) begin
                    if (bus.commit_rat_commit_phy_id_valid[c]) begin
                        w_valid_nxt[bus.commit_rat_commit_phy_id[c]] = 1'b1;
                    end
                end
            end
            // Slots in index order against the already-updated arch ids, so a
            // later slot on the same arch hides the earlier slot's mapping.
            if (bus.rename_rat_map) begin
                for (int r = 0; r < RENAME_WIDTH; r++) begin
                    if (bus.rename_rat_phy_id_valid[r]) begin
                        for (int i = 0; i < PHY_REG_NUM; i++) begin
                            if (w_arch_nxt[i] == bus.rename_rat_arch_id[r]) begin
                                w_visible_nxt[i] = 1'b0;
                            end
                        end
                        w_arch_nxt[bus.rename_rat_phy_id[r]]    = bus.rename_rat_arch_id[r];
                        w_valid_nxt[bus.rename_rat_phy_id[r]]   = 1'b1;
                        w_visible_nxt[bus.rename_rat_phy_id[r]] = 1'b1;
                    end
                end
            end
        end
    end

    // Table state register with identity mapping on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHY_REG_NUM; i++) begin
                r_arch[i] <= (i < ARCH_REG_NUM) ? arch_id_t'(i) : '0;
            end
            r_valid   <= RESET_VEC;
            r_visible <= RESET_VEC;
        end else begin
            r_arch    <= w_arch_nxt;
            r_valid   <= w_valid_nxt;
            r_visible <= w_visible_nxt;
        end
    end

    assign bus.rat_rename_new_phy_id        = w_new_phy;
    assign bus.rat_rename_new_phy_id_valid  = w_new_valid;
    assign bus.rat_rename_read_phy_id       = w_read_phy;
    assign bus.rat_rename_map_table_valid   = r_valid;
    assign bus.rat_rename_map_table_visible = r_visible;

`ifdef RAT_ASSERT_EN
    // Simulation-only consistency checks on incoming updates and lookups.
    always @(posedge clk) begin : g_rat_checks
        int n_match;
        if (!rst) begin
            if (bus.rename_rat_map && !bus.commit_rat_map_table_restore) begin
                for (int r = 0; r < RENAME_WIDTH; r++) begin
                    if (bus.rename_rat_phy_id_valid[r]) begin
                        assert (!r_valid[bus.rename_rat_phy_id[r]])
                            else $error("rat_table: rename onto valid entry %0d", bus.rename_rat_phy_id[r]);
                    end
                end
            end
            if (bus.commit_rat_release_map && !bus.commit_rat_map_table_restore) begin
                for (int c = 0; c < COMMIT_WIDTH; c++) begin
                    if (bus.commit_rat_release_phy_id_valid[c]) begin
                        assert (r_valid[bus.commit_rat_release_phy_id[c]])
                            else $error("rat_table: release of invalid entry %0d", bus.commit_rat_release_phy_id[c]);
                    end
                end
            end
            for (int r = 0; r < RENAME_WIDTH; r++) begin
                for (int k = 0; k < READ_PORTS; k++) begin
                    n_match = 0;
                    if (bus.rename_rat_read_arch_id[r][k] != ARCH_ID_NONE) begin
                        for (int i = 0; i < PHY_REG_NUM; i++) begin
                            if (r_valid[i] && r_visible[i] &&
                                (r_arch[i] == bus.rename_rat_read_arch_id[r][k])) begin
                                n_match = n_match + 1;
                            end
                        end
                    end
                    assert (n_match <= 1)
                        else $error("rat_table: arch %0d maps to %0d visible entries",
                                    bus.rename_rat_read_arch_id[r][k], n_match);
                end
            end
        end
    end
`endif

endmodule : rat_table
`default_nettype wire

// File: tb/tb_rat_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_table
// Description : Self-checking bench for rat_table: reset state, then a table
//               of per-cycle update vectors with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_table;
    import rat_table_pkg::*;

    localparam logic [63:0] RV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rat_table_if bus ();

    rat_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        map;   logic [1:0] pv;   logic [5:0] p0;  logic [5:0] p1;
        logic [7:0]  a0;    logic [7:0] a1;
        logic        rel;   logic [1:0] relv; logic [5:0] r0;  logic [5:0] r1;
        logic        rb;    logic [5:0] rbn;  logic [5:0] rbo;
        logic        cm;    logic [1:0] cmv;  logic [5:0] c0;
        logic        rs;    logic [63:0] rsv; logic [63:0] rsvis;
        logic [7:0]  rd0;   logic [7:0] rd1;
        logic [5:0]  e_rd0; logic [5:0] e_rd1;
        logic [1:0]  e_offv; logic [5:0] e_off0; logic [5:0] e_off1;
        logic [63:0] e_valid; logic [63:0] e_vis;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.rename_rat_map                  = 1'b0;
        bus.rename_rat_phy_id_valid         = '0;
        bus.commit_rat_map_table_restore    = 1'b0;
        bus.commit_rat_map_table_valid      = '0;
        bus.commit_rat_map_table_visible    = '0;
        bus.commit_rat_release_map          = 1'b0;
        bus.commit_rat_release_phy_id_valid = '0;
        bus.commit_rat_commit_map           = 1'b0;
        bus.commit_rat_commit_phy_id_valid  = '0;
        bus.commit_rat_restore_map          = 1'b0;
        bus.commit_rat_restore_new_phy_id   = '0;
        bus.commit_rat_restore_old_phy_id   = '0;
        for (int r = 0; r < RENAME_WIDTH; r++) begin
            bus.rename_rat_phy_id[r]  = '0;
            bus.rename_rat_arch_id[r] = '0;
            for (int k = 0; k < READ_PORTS; k++) bus.rename_rat_read_arch_id[r][k] = 8'd255;
        end
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            bus.commit_rat_release_phy_id[c] = '0;
            bus.commit_rat_commit_phy_id[c]  = '0;
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        idle();
        bus.rename_rat_map                  = v.map;
        bus.rename_rat_phy_id_valid         = v.pv;
        bus.rename_rat_phy_id[0]            = v.p0;
        bus.rename_rat_phy_id[1]            = v.p1;
        bus.rename_rat_arch_id[0]           = v.a0;
        bus.rename_rat_arch_id[1]           = v.a1;
        bus.commit_rat_release_map          = v.rel;
        bus.commit_rat_release_phy_id_valid = v.relv;
        bus.commit_rat_release_phy_id[0]    = v.r0;
        bus.commit_rat_release_phy_id[1]    = v.r1;
        bus.commit_rat_restore_map          = v.rb;
        bus.commit_rat_restore_new_phy_id   = v.rbn;
        bus.commit_rat_restore_old_phy_id   = v.rbo;
        bus.commit_rat_commit_map           = v.cm;
        bus.commit_rat_commit_phy_id_valid  = v.cmv;
        bus.commit_rat_commit_phy_id[0]     = v.c0;
        bus.commit_rat_map_table_restore    = v.rs;
        bus.commit_rat_map_table_valid      = v.rsv;
        bus.commit_rat_map_table_visible    = v.rsvis;
        @(posedge clk);
        #1;
        idle();
        bus.rename_rat_read_arch_id[0][0] = v.rd0;
        bus.rename_rat_read_arch_id[1][2] = v.rd1;
        #1;
        chk({v.name, " rd0"},     64'(bus.rat_rename_read_phy_id[0][0]), 64'(v.e_rd0));
        chk({v.name, " rd1"},     64'(bus.rat_rename_read_phy_id[1][2]), 64'(v.e_rd1));
        chk({v.name, " offv"},    64'(bus.rat_rename_new_phy_id_valid),  64'(v.e_offv));
        if (v.e_offv[0]) chk({v.name, " off0"}, 64'(bus.rat_rename_new_phy_id[0]), 64'(v.e_off0));
        if (v.e_offv[1]) chk({v.name, " off1"}, 64'(bus.rat_rename_new_phy_id[1]), 64'(v.e_off1));
        chk({v.name, " valid"},   bus.rat_rename_map_table_valid,   v.e_valid);
        chk({v.name, " visible"}, bus.rat_rename_map_table_visible, v.e_vis);
    endtask

    initial begin
        //            name            map pv    p0 p1 a0 a1  rel relv  r0 r1  rb rbn rbo cm cmv c0  rs rsv   rsvis rd0 rd1  erd0 erd1 offv  off0 off1 valid                   visible
        vecs[0]  = '{"map_a5_p32",    1, 2'b01, 32, 0, 5, 0,  0, 2'b00, 0, 0,  0, 0, 0,  0, 2'b00, 0, 0, '0, '0, 5, 255, 32, 0, 2'b11, 33, 34, 64'h1_FFFF_FFFF, 64'h1_FFFF_FFDF};
        vecs[1]  = '{"rollback",      0, 2'b00, 0, 0, 0, 0,   0, 2'b00, 0, 0,  1, 32, 5, 0, 2'b00, 0, 0, '0, '0, 5, 255, 5, 0, 2'b11, 32, 33, RV, RV};
        vecs[2]  = '{"dual_a7",       1, 2'b11, 32, 33, 7, 7, 0, 2'b00, 0, 0,  0, 0, 0,  0, 2'b00, 0, 0, '0, '0, 7, 6, 33, 6, 2'b11, 34, 35, 64'h3_FFFF_FFFF, 64'h2_FFFF_FF7F};
        vecs[3]  = '{"rel_vs_ren",    1, 2'b01, 5, 0, 5, 0,   1, 2'b01, 5, 0,  0, 0, 0,  0, 2'b00, 0, 0, '0, '0, 5, 7, 5, 33, 2'b11, 34, 35, 64'h3_FFFF_FFFF, 64'h2_FFFF_FF7F};
        vecs[4]  = '{"release2",      0, 2'b00, 0, 0, 0, 0,   1, 2'b11, 7, 32, 0, 0, 0,  0, 2'b00, 0, 0, '0, '0, 7, 3, 33, 3, 2'b11, 7, 32, 64'h2_FFFF_FF7F, 64'h2_FFFF_FF7F};
        vecs[5]  = '{"map_slot1",     1, 2'b10, 40, 7, 9, 3,  1, 2'b00, 33, 0, 0, 0, 0,  0, 2'b00, 0, 0, '0, '0, 3, 9, 7, 9, 2'b11, 32, 34, 64'h2_FFFF_FFFF, 64'h2_FFFF_FFF7};
        vecs[6]  = '{"commit",        0, 2'b00, 0, 0, 0, 0,   0, 2'b00, 0, 0,  0, 0, 0,  1, 2'b01, 32, 0, '0, '0, 7, 3, 33, 7, 2'b11, 34, 35, 64'h3_FFFF_FFFF, 64'h2_FFFF_FFF7};
        vecs[7]  = '{"strobes_off",   0, 2'b11, 40, 41, 1, 2, 0, 2'b11, 0, 1,  0, 0, 40, 0, 2'b01, 50, 0, '0, '0, 1, 255, 1, 0, 2'b11, 34, 35, 64'h3_FFFF_FFFF, 64'h2_FFFF_FFF7};
        vecs[8]  = '{"restore_reset", 1, 2'b01, 34, 0, 5, 0,  1, 2'b01, 0, 0,  0, 0, 0,  0, 2'b00, 0, 1, RV, RV, 5, 2, 5, 2, 2'b11, 32, 33, RV, RV};
        vecs[9]  = '{"one_free",      0, 2'b00, 0, 0, 0, 0,   0, 2'b00, 0, 0,  0, 0, 0,  0, 2'b00, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, RV, 5, 255, 5, 0, 2'b01, 63, 0, 64'h7FFF_FFFF_FFFF_FFFF, RV};
        vecs[10] = '{"full",          0, 2'b00, 0, 0, 0, 0,   0, 2'b00, 0, 0,  0, 0, 0,  0, 2'b00, 0, 1, '1, RV, 5, 255, 5, 0, 2'b00, 0, 0, '1, RV};
        vecs[11] = '{"restore_back",  0, 2'b00, 0, 0, 0, 0,   0, 2'b00, 0, 0,  0, 0, 0,  0, 2'b00, 0, 1, RV, RV, 4, 255, 4, 0, 2'b11, 32, 33, RV, RV};

        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.rename_rat_read_arch_id[0][0] = 8'd5;
        bus.rename_rat_read_arch_id[1][2] = 8'd31;
        bus.rename_rat_read_arch_id[0][1] = 8'd255;
        #1;
        chk("reset valid",   bus.rat_rename_map_table_valid,   RV);
        chk("reset visible", bus.rat_rename_map_table_visible, RV);
        chk("reset offv",    64'(bus.rat_rename_new_phy_id_valid), 64'd3);
        chk("reset off0",    64'(bus.rat_rename_new_phy_id[0]), 64'd32);
        chk("reset off1",    64'(bus.rat_rename_new_phy_id[1]), 64'd33);
        chk("reset rd a5",   64'(bus.rat_rename_read_phy_id[0][0]), 64'd5);
        chk("reset rd a31",  64'(bus.rat_rename_read_phy_id[1][2]), 64'd31);
        chk("reset rd none", 64'(bus.rat_rename_read_phy_id[0][1]), 64'd0);

        // Inputs presented mid-cycle must not reach the outputs before the edge.
        bus.rename_rat_map          = 1'b1;
        bus.rename_rat_phy_id_valid = 2'b01;
        bus.rename_rat_phy_id[0]    = 6'd32;
        bus.rename_rat_arch_id[0]   = 8'd5;
        #1;
        chk("comb rd a5", 64'(bus.rat_rename_read_phy_id[0][0]), 64'd5);
        chk("comb valid", bus.rat_rename_map_table_valid, RV);
        chk("comb off0",  64'(bus.rat_rename_new_phy_id[0]), 64'd32);
        idle();

        for (int n = 0; n < 12; n++) begin
            apply(vecs[n]);
        end

        // Reset from a modified state returns to the identity image.
        apply(vecs[0]);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rename_rat_read_arch_id[0][0] = 8'd5;
        #1;
        chk("rereset valid",   bus.rat_rename_map_table_valid,   RV);
        chk("rereset visible", bus.rat_rename_map_table_visible, RV);
        chk("rereset rd a5",   64'(bus.rat_rename_read_phy_id[0][0]), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rat_table
`default_nettype wire
